// File: rtl/demux_1_4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//   SEL_W / N_PORTS : width of the destination select and number of output ports
//   PORT_A..PORT_D  : destination indices carried on in_sel
//   slot_state_e    : state of a one-entry output holding register
//   sel_decode()    : destination index -> one-hot port mask
package demux_1_4_stream_pkg;

    localparam int SEL_W   = 2;
    localparam int N_PORTS = 4;

    localparam logic [SEL_W-1:0] PORT_A = 2'd0;
    localparam logic [SEL_W-1:0] PORT_B = 2'd1;
    localparam logic [SEL_W-1:0] PORT_C = 2'd2;
    localparam logic [SEL_W-1:0] PORT_D = 2'd3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [N_PORTS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [N_PORTS-1:0] onehot;
        case (sel)
            PORT_A:  onehot = 4'b0001;
            PORT_B:  onehot = 4'b0010;
            PORT_C:  onehot = 4'b0100;
            PORT_D:  onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output port of the demultiplexer: a one-entry valid/ready holding
// register plus a saturating count of beats handed to the consumer.
//   clk, rstn        : clock, asynchronous active-low reset
//   load, load_data  : upstream writes a beat into this slot (only when it can accept)
//   out_valid/ready  : downstream handshake; out_data holds the slot contents
//   cnt_clr          : synchronous clear of cnt, wins over a same-cycle increment
//   cnt              : beats delivered, saturating at all-ones
module demux_out_slot
    import demux_1_4_stream_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
);

    slot_state_e      state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        drain = (state_q == SLOT_FULL) && out_ready;

        case (state_q)
            SLOT_EMPTY: if (load)           state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
            default:                        state_d = SLOT_EMPTY;
        endcase

        // A refill in the same cycle as a drain simply overwrites: no bubble.
        if (load) data_d = load_data;

        if (cnt_clr)
            cnt_d = '0;
        else if (drain && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: the data register is reset too, so out_data never shows X after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each accepted input beat is written
// into the holding slot of the port named by in_sel; each port drains
// independently through its own valid/ready handshake.
//   clk, rstn           : clock, asynchronous active-low reset
//   in_valid/in_ready   : producer handshake; in_ready looks only at the selected port
//   in_data, in_sel     : beat payload and destination (0..3 -> a..d)
//   out_valid/out_ready : per-port consumer handshakes, bit i = port i
//   out_data            : lane i = out_data[i*W +: W]
//   cnt_clr, cnt        : clear and read per-port delivered-beat counters
module demux_1_4_stream
    import demux_1_4_stream_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_PORTS-1:0]     out_valid,
    input  logic [N_PORTS-1:0]     out_ready,
    output logic [N_PORTS*W-1:0]   out_data,
    input  logic                   cnt_clr,
    output logic [N_PORTS*CNT_W-1:0] cnt
);

    logic [N_PORTS-1:0] sel_onehot;
    logic [N_PORTS-1:0] load;
    logic               accept;

    always_comb begin
        sel_onehot = sel_decode(in_sel);
        // The selected slot can take a beat if it is empty or is draining this
        // same cycle. Other ports being full never blocks the producer.
        in_ready   = rstn & (~out_valid[in_sel] | out_ready[in_sel]);
        accept     = in_valid & in_ready;
        load       = sel_onehot & {N_PORTS{accept}};
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : g_slot
        demux_out_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .load      (load[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*W +: W]),
            .cnt_clr   (cnt_clr),
            .cnt       (cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream. Two instances share all inputs:
// one with 8-bit counters and one with 2-bit counters so saturation is easy
// to reach. A queue-free behavioural model tracks each port as
// {full, payload, delivered count}; a compare process checks both DUTs against
// it every negative clock edge, and directed sections pin literal values.
module tb_demux_1_4_stream;

    localparam int W       = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_W_S = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid;
    logic [1:0]           in_sel;
    logic [W-1:0]         in_data;
    logic [3:0]           out_ready;
    logic                 cnt_clr;

    logic                 in_ready,  in_ready_s;
    logic [3:0]           out_valid, out_valid_s;
    logic [4*W-1:0]       out_data,  out_data_s;
    logic [4*CNT_W-1:0]   cnt;
    logic [4*CNT_W_S-1:0] cnt_s;

    always #5 clk = ~clk;

    demux_1_4_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .cnt_clr(cnt_clr), .cnt(cnt)
    );

    demux_1_4_stream #(.W(W), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .cnt_clr(cnt_clr), .cnt(cnt_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]   m_valid;
    logic [W-1:0] m_data [4];
    int           m_cnt  [4];
    int           m_cnt_s[4];
    logic         m_acc;

    function automatic int sat_inc(input int c, input int width);
        return (c >= (1 << width) - 1) ? c : c + 1;
    endfunction

    initial begin
        m_valid = '0;
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0; m_cnt[i] = 0; m_cnt_s[i] = 0;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid = '0;
            for (int i = 0; i < 4; i++) begin
                m_data[i] = '0; m_cnt[i] = 0; m_cnt_s[i] = 0;
            end
        end else begin
            m_acc = in_valid && (!m_valid[in_sel] || out_ready[in_sel]);
            for (int i = 0; i < 4; i++) begin
                if (cnt_clr) begin
                    m_cnt[i] = 0; m_cnt_s[i] = 0;
                end else if (m_valid[i] && out_ready[i]) begin
                    m_cnt[i]   = sat_inc(m_cnt[i], CNT_W);
                    m_cnt_s[i] = sat_inc(m_cnt_s[i], CNT_W_S);
                end
                if (m_acc && (int'(in_sel) == i)) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = in_data;
                end else if (m_valid[i] && out_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic                 e_rdy;
    logic [4*W-1:0]       e_data;
    logic [4*CNT_W-1:0]   e_cnt;
    logic [4*CNT_W_S-1:0] e_cnt_s;

    always @(negedge clk) begin
        e_rdy = rstn && (!m_valid[in_sel] || out_ready[in_sel]);
        for (int i = 0; i < 4; i++) begin
            e_data[i*W +: W]             = m_data[i];
            e_cnt[i*CNT_W +: CNT_W]      = CNT_W'(m_cnt[i]);
            e_cnt_s[i*CNT_W_S +: CNT_W_S] = CNT_W_S'(m_cnt_s[i]);
        end
        check("in_ready",    in_ready,    e_rdy);
        check("in_ready_s",  in_ready_s,  e_rdy);
        check("out_valid",   out_valid,   m_valid);
        check("out_valid_s", out_valid_s, m_valid);
        check("out_data",    out_data,    e_data);
        check("out_data_s",  out_data_s,  e_data);
        check("cnt",         cnt,         e_cnt);
        check("cnt_s",       cnt_s,       e_cnt_s);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] ordy, input logic clr);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        cnt_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] route_d [4];
    logic [W-1:0] sdat;

    initial begin
        rstn = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
        repeat (2) tick();
        @(negedge clk);
        check("reset_in_ready",  in_ready,  1'b0);
        check("reset_out_valid", out_valid, 4'b0000);
        check("reset_cnt",       cnt,       32'h0);
        tick();
        rstn = 1'b1;

        // Routing: one beat to each port, all consumers ready.
        route_d[0] = 4'h4; route_d[1] = 4'h1; route_d[2] = 4'h9; route_d[3] = 4'h3;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), route_d[k], 4'hF, 1'b0);
            @(negedge clk);
            check("route_in_ready", in_ready, 1'b1);
            if (k > 0) begin
                check("route_valid", out_valid, 4'(1 << (k - 1)));
                check("route_lane",  out_data[(k-1)*W +: W], route_d[k-1]);
            end
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("route_valid_d", out_valid, 4'b1000);
        tick();
        @(negedge clk);
        check("route_cnt",  cnt,       32'h01010101);
        check("route_hold", out_data,  16'h3914);
        check("route_idle", out_valid, 4'b0000);
        tick();

        // Backpressure on port c; port a still accepts meanwhile.
        drive(1'b1, 2'd2, 4'h9, 4'b1011, 1'b0);
        @(negedge clk);
        check("bp_first_ready", in_ready, 1'b1);
        tick();
        drive(1'b1, 2'd2, 4'h7, 4'b1011, 1'b0);
        @(negedge clk);
        check("bp_blocked",   in_ready,  1'b0);
        check("bp_valid",     out_valid, 4'b0100);
        tick();
        @(negedge clk);
        check("bp_still_blocked", in_ready, 1'b0);
        tick();
        drive(1'b1, 2'd0, 4'h5, 4'b1011, 1'b0);
        @(negedge clk);
        check("bp_other_port", in_ready, 1'b1);
        tick();
        drive(1'b1, 2'd2, 4'h7, 4'b1011, 1'b0);
        @(negedge clk);
        check("bp_blocked_again", in_ready, 1'b0);
        check("bp_valid_ac",      out_valid, 4'b0101);
        check("bp_lane_a",        out_data[0 +: W], 4'h5);
        check("bp_lane_c",        out_data[2*W +: W], 4'h9);
        tick();
        drive(1'b1, 2'd2, 4'h7, 4'hF, 1'b0);
        @(negedge clk);
        check("bp_drain_refill_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("bp_no_bubble", out_valid, 4'b0100);
        check("bp_lane_c_new", out_data[2*W +: W], 4'h7);
        tick();
        @(negedge clk);
        check("bp_cnt_c", cnt[2*CNT_W +: CNT_W], 8'd3);
        check("bp_cnt_a", cnt[0 +: CNT_W], 8'd2);
        tick();

        // Back-to-back stream to port b.
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd1, 4'(3 * k + 2), 4'hF, 1'b0);
            @(negedge clk);
            check("stream_ready", in_ready, 1'b1);
            if (k > 0) begin
                sdat = 4'(3 * (k - 1) + 2);
                check("stream_valid", out_valid, 4'b0010);
                check("stream_lane",  out_data[W +: W], sdat);
            end
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("stream_last", out_data[W +: W], 4'h7);
        tick();
        @(negedge clk);
        check("stream_cnt_b", cnt[CNT_W +: CNT_W], 8'd8);
        tick();

        // Saturation of the 2-bit counter, then clear racing a drain.
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd3, 4'(k), 4'hF, 1'b0);
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("sat_cnt_s_d", cnt_s[3*CNT_W_S +: CNT_W_S], 2'd3);
        check("sat_cnt_d",   cnt[3*CNT_W +: CNT_W],       8'd5);
        tick();
        drive(1'b1, 2'd3, 4'hA, 4'hF, 1'b0);
        tick();
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b1);
        @(negedge clk);
        check("clr_drain_valid", out_valid[3], 1'b1);
        tick();
        drive(1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("clr_cnt_s_d", cnt_s[3*CNT_W_S +: CNT_W_S], 2'd0);
        check("clr_cnt_d",   cnt[3*CNT_W +: CNT_W],       8'd0);
        check("clr_idle",    out_valid,                    4'b0000);
        tick();

        // in_sel / in_data wiggling with in_valid low has no effect.
        drive(1'b1, 2'd0, 4'hC, 4'h0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'(k), 4'(k + 5), 4'h0, 1'b0);
            @(negedge clk);
            check("glitch_valid", out_valid, 4'b0001);
            check("glitch_lane",  out_data[0 +: W], 4'hC);
            check("glitch_cnt",   cnt, 32'h0);
            tick();
        end

        // Asynchronous reset with every slot full and a non-zero counter.
        drive(1'b0, 2'd0, 4'h0, 4'b0001, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 4'(k + 11), 4'h0, 1'b0);
            tick();
        end
        drive(1'b1, 2'd0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("pre_reset_valid", out_valid, 4'hF);
        check("pre_reset_cnt_a", cnt[0 +: CNT_W], 8'd1);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 4'h0);
        check("async_rst_data",  out_data,  16'h0);
        check("async_rst_cnt",   cnt,       32'h0);
        check("async_rst_ready", in_ready,  1'b0);
        tick();
        tick();
        rstn = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                  {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                  ($urandom_range(0, 1023) == 0));
            if ($urandom_range(0, 999) == 0) rstn = 1'b0;
            else if (!rstn && $urandom_range(0, 1) == 0) rstn = 1'b1;
            tick();
        end
        rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
